// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction RAM. It collects a byte stream, packs each
//   group of four bytes into one big-endian word and writes that word through
//   the RAM write port. While a load is running it holds the fetch stage.
//
// Ports
//   clk, reset   : system clock; synchronous active-high reset
//   start        : one-cycle load request, sampled only while idle
//   base_addr    : first RAM word address, captured with start
//   num_words    : word count, captured with start (clamped to RAM depth)
//   rx_data/rx_valid/rx_ready : byte stream handshake (rx_ready from state)
//   ram_addr/ram_data/ram_we/ram_en : RAM write port, ram_en mirrors ram_we
//   cpu_hold     : stall request to fetch, same as busy
//   busy         : load in progress
//   done         : level, set when the last load finished, cleared by start
//   len_err      : last accepted start asked for more words than RAM depth
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_words,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we,
   output logic              ram_en,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              len_err
);

   // RAM depth as a count; needs one bit more than an address
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_FINISH  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;       // next RAM address to write
   logic [ADDR_W:0]     wcnt_q, wcnt_d;       // words still to load
   logic [1:0]          bcnt_q, bcnt_d;       // bytes of current word taken
   logic [DATA_W-9:0]   shift_q, shift_d;     // first three bytes of a word
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_data_q, ram_data_d;
   logic                ram_we_q, ram_we_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                len_err_q, len_err_d;

   logic                accept;
   logic                last_byte;
   logic [ADDR_W:0]     num_sat;
   logic                num_ovf;

   assign rx_ready  = (state_q == S_COLLECT);
   assign accept    = rx_ready && rx_valid;
   assign last_byte = accept && (bcnt_q == 2'd3);
   assign num_ovf   = (num_words > DEPTH);
   assign num_sat   = num_ovf ? DEPTH : num_words;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = (num_sat == '0) ? S_FINISH : S_COLLECT;
         end
         S_COLLECT: begin
            if (last_byte) state_d = S_WRITE;
         end
         S_WRITE: begin
            // remaining count reaches zero after this write
            state_d = (wcnt_q == ONE) ? S_FINISH : S_COLLECT;
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- registered outputs ----------------
   // Write strobe and busy are decoded from the next state so they line up
   // with the state they describe, without a combinational output path.
   always_comb begin
      ram_we_d  = (state_d == S_WRITE);
      busy_d    = (state_d != S_IDLE);
      done_d    = done_q;
      len_err_d = len_err_q;
      if (state_q == S_IDLE && start) begin
         done_d    = 1'b0;
         len_err_d = num_ovf;
      end else if (state_q == S_FINISH) begin
         done_d    = 1'b1;
      end
   end

   // ---------------- datapath ----------------
   always_comb begin
      addr_d     = addr_q;
      wcnt_d     = wcnt_q;
      bcnt_d     = bcnt_q;
      shift_d    = shift_q;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d = base_addr;
               wcnt_d = num_sat;
               bcnt_d = 2'd0;
            end
         end
         S_COLLECT: begin
            if (accept) begin
               bcnt_d  = bcnt_q + 2'd1;
               shift_d = {shift_q[DATA_W-17:0], rx_data};
               if (last_byte) begin
                  // earliest byte sits in the top of shift_q
                  ram_data_d = {shift_q, rx_data};
                  ram_addr_d = addr_q;
               end
            end
         end
         S_WRITE: begin
            addr_d = addr_q + 1'b1;       // wraps at RAM depth
            wcnt_d = wcnt_q - ONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         wcnt_q     <= '0;
         bcnt_q     <= '0;
         shift_q    <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         ram_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         wcnt_q     <= wcnt_d;
         bcnt_q     <= bcnt_d;
         shift_q    <= shift_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         ram_we_q   <= ram_we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         len_err_q  <= len_err_d;
      end
   end

   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign ram_we   = ram_we_q;
   assign ram_en   = ram_we_q;
   assign busy     = busy_q;
   assign cpu_hold = busy_q;
   assign done     = done_q;
   assign len_err  = len_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed stimulus for imem_loader. Each load pushes its expected RAM
//   writes into a queue; a monitor pops and compares on every ram_we pulse.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  base_addr;
   logic [4:0]  num_words;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [3:0]  ram_addr;
   logic [31:0] ram_data;
   logic        ram_we;
   logic        ram_en;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        len_err;

   imem_loader #(.ADDR_W(4), .DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_we    (ram_we),
      .ram_en    (ram_en),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] wtab[16];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          we_cnt = 0;
   int          we_cyc_last = 0;
   int          we_cyc_prev = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      wr_t e;
      if (ram_we === 1'b1) begin
         we_cnt++;
         we_cyc_prev = we_cyc_last;
         we_cyc_last = cyc;
         chk("ram_en_eq_we", {31'd0, ram_en}, 32'd1);
         chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", ram_addr, ram_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {28'd0, ram_addr}, {28'd0, e.a});
            chk("wr_data", ram_data, e.d);
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic do_start(input logic [3:0] b, input logic [4:0] n);
      start = 1'b1; base_addr = b; num_words = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int  t;
      bit  acc;
      rx_data = b; rx_valid = 1'b1; t = 0; acc = 1'b0;
      while (!acc && t < 50) begin
         acc = rx_ready;           // transfer happens at the coming posedge
         @(negedge clk);
         t++;
      end
      if (!acc) chk("byte_accept_timeout", {31'd0, acc}, 32'd1);
      if (gap > 0) begin
         rx_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], gap);
   endtask

   task automatic wait_done();
      int t = 0;
      while (done !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("done_set", {31'd0, done}, 32'd1);
      chk("busy_clear", {31'd0, busy}, 32'd0);
      chk("hold_clear", {31'd0, cpu_hold}, 32'd0);
   endtask

   task automatic load(input logic [3:0] b, input logic [4:0] n, input int gap);
      int  eff;
      int  w0;
      wr_t e;
      eff = (n > 5'd16) ? 16 : int'(n);
      for (int i = 0; i < eff; i++) begin
         e.a = b + 4'(i);
         e.d = wtab[i];
         exp_q.push_back(e);
      end
      w0 = we_cnt;
      do_start(b, n);
      chk("busy_during_load", {31'd0, busy}, {31'd0, (eff != 0)});
      for (int i = 0; i < eff; i++) send_word(wtab[i], gap);
      rx_valid = 1'b0;
      wait_done();
      chk("write_count", 32'(we_cnt - w0), 32'(eff));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
      chk({tag, "_ram_addr"}, {28'd0, ram_addr}, 32'd0);
      chk({tag, "_ram_data"}, ram_data, 32'd0);
      chk({tag, "_ram_we"},   {31'd0, ram_we}, 32'd0);
      chk({tag, "_ram_en"},   {31'd0, ram_en}, 32'd0);
      chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
      chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
      chk({tag, "_done"},     {31'd0, done}, 32'd0);
      chk({tag, "_len_err"},  {31'd0, len_err}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      wr_t e;
      reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
      rx_data = '0; rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      // basic load, valid held high
      wtab[0] = 32'h2008_0005;
      wtab[1] = 32'hAC01_0004;
      load(4'd0, 5'd2, 0);
      chk("we_spacing", 32'(we_cyc_last - we_cyc_prev), 32'd5);
      chk("len_err_basic", {31'd0, len_err}, 32'd0);

      // same stream with 3-cycle gaps between bytes
      load(4'd0, 5'd2, 3);

      // address wrap
      wtab[0] = 32'h1122_3344;
      wtab[1] = 32'h5566_7788;
      load(4'd15, 5'd2, 0);

      // zero length: done two cycles after start, no write
      w0 = we_cnt;
      do_start(4'd9, 5'd0);
      chk("zero_done_low", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("zero_done_high", {31'd0, done}, 32'd1);
      chk("zero_busy", {31'd0, busy}, 32'd0);
      chk("zero_no_write", 32'(we_cnt - w0), 32'd0);

      // length clamp: 20 requested, 16 written
      for (int i = 0; i < 16; i++)
         wtab[i] = {8'(8'h10 + i), 8'(i), 8'hA5, 8'(8'hF0 ^ i)};
      w0 = we_cnt;
      load(4'd0, 5'd20, 0);
      chk("clamp_len_err", {31'd0, len_err}, 32'd1);
      chk("clamp_last_addr", {28'd0, ram_addr}, 32'd15);

      // start during busy is ignored
      wtab[0] = 32'h0102_0304;
      wtab[1] = 32'h0506_0708;
      wtab[2] = 32'h090A_0B0C;
      for (int i = 0; i < 3; i++) begin
         e.a = 4'(i);
         e.d = wtab[i];
         exp_q.push_back(e);
      end
      w0 = we_cnt;
      do_start(4'd0, 5'd3);
      chk("busy_start_len_err_cleared", {31'd0, len_err}, 32'd0);
      send_word(wtab[0], 0);
      rx_valid = 1'b0;
      start = 1'b1; base_addr = 4'd7; num_words = 5'd5;
      repeat (2) @(negedge clk);
      start = 1'b0;
      chk("busy_start_done_low", {31'd0, done}, 32'd0);
      send_word(wtab[1], 0);
      send_word(wtab[2], 1);
      rx_valid = 1'b0;
      wait_done();
      chk("busy_start_writes", 32'(we_cnt - w0), 32'd3);
      chk("busy_start_drained", 32'(exp_q.size()), 32'd0);

      // reset mid-load: partial word dropped, outputs cleared
      do_start(4'd3, 5'd2);
      send_byte(8'hCA, 0);
      send_byte(8'hFE, 0);
      exp_q.delete();
      w0 = we_cnt;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_outputs("midreset");
      rx_data = 8'hF0;
      repeat (6) @(negedge clk);
      rx_valid = 1'b0;
      chk("midreset_no_write", 32'(we_cnt - w0), 32'd0);
      chk("midreset_idle_ready", {31'd0, rx_ready}, 32'd0);
      wtab[0] = 32'hDEAD_BEEF;
      load(4'd5, 5'd1, 0);

      // start and reset together: reset wins
      start = 1'b1; base_addr = 4'd2; num_words = 5'd4; reset = 1'b1;
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      chk("start_reset_busy", {31'd0, busy}, 32'd0);
      chk("start_reset_ready", {31'd0, rx_ready}, 32'd0);
      @(negedge clk);
      chk("start_reset_still_idle", {31'd0, busy}, 32'd0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
